// File: rtl/mc_if.sv
// mc_if: handshake and datapath-select bundle between mc_ctrl and the MIPS datapath
interface mc_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 32
);
  logic                    start;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    mem_ready;
  logic                    mem_read;
  logic                    mem_write;
  logic                    i_or_d;
  logic                    ir_wrt;
  logic                    pc_wrt;
  logic                    pc_wrt_cond;
  logic                    reg_wrt;
  logic                    reg_dst;
  logic                    mem_to_reg;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic [1:0]              alu_op;
  logic [1:0]              pc_src;
  logic                    busy;
  logic                    fault;
  logic [1:0]              fault_code;
  logic [CNT_WIDTH-1:0]    instr_cnt;
  modport master (
    input  start, opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_wrt, pc_wrt, pc_wrt_cond, reg_wrt,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           busy, fault, fault_code, instr_cnt
  );
  modport slave (
    output start, opcode, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_wrt, pc_wrt, pc_wrt_cond, reg_wrt,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           busy, fault, fault_code, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory-wait watchdog and retired-instruction counter
module mc_ctrl #(
  parameter int OPCODE_WIDTH = 6,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_WIDTH    = 32
) (
  input logic   clk,
  input logic   rst,
  mc_if.master  bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, WB_I,
    MEM_RD, WB_LD, MEM_WR, BRANCH, JUMP, FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [1:0]           fc_q, fc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mem_wait, timeout, retire;

  assign mem_wait = state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR;
  // the ready cycle wins over an expiring watchdog, so timeout requires mem_ready low
  assign timeout  = mem_wait && !bus.mem_ready && tmo_q == TW'(MEM_TIMEOUT - 1);

  // next-state, fault code and retirement decisions
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:   state_d = bus.start ? FETCH : IDLE;
      FETCH:  begin
        if (bus.mem_ready) state_d = DECODE;
        else if (timeout) begin
          state_d = FAULT;
          fc_d    = 2'd2;
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_R:                     state_d = EXEC_R;
          OP_LW, OP_SW, OP_ADDI:    state_d = ADDR;
          OP_BEQ:                   state_d = BRANCH;
          OP_J:                     state_d = JUMP;
          default: begin
            state_d = FAULT;
            fc_d    = 2'd1;
          end
        endcase
      end
      EXEC_R: state_d = WB_R;
      ADDR:   begin
        case (bus.opcode)
          OP_LW:   state_d = MEM_RD;
          OP_SW:   state_d = MEM_WR;
          OP_ADDI: state_d = WB_I;
          default: begin
            state_d = FAULT;
            fc_d    = 2'd1;
          end
        endcase
      end
      MEM_RD: begin
        if (bus.mem_ready) state_d = WB_LD;
        else if (timeout) begin
          state_d = FAULT;
          fc_d    = 2'd2;
        end
      end
      MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = FAULT;
          fc_d    = 2'd2;
        end
      end
      WB_R, WB_I, WB_LD, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FAULT;
    endcase
  end

  // watchdog counts stalled memory cycles and restarts whenever the state moves
  always_comb begin
    tmo_d = (state_d == state_q && mem_wait && !bus.mem_ready) ? tmo_q + 1'b1 : '0;
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  // state, watchdog, fault code and instruction counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      fc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_read    = state_q == FETCH || state_q == MEM_RD;
  assign bus.mem_write   = state_q == MEM_WR;
  assign bus.i_or_d      = state_q == MEM_RD || state_q == MEM_WR;
  assign bus.ir_wrt      = state_q == FETCH && bus.mem_ready;
  assign bus.pc_wrt      = (state_q == FETCH && bus.mem_ready) || state_q == JUMP;
  assign bus.pc_wrt_cond = state_q == BRANCH;
  assign bus.reg_wrt     = state_q == WB_R || state_q == WB_I || state_q == WB_LD;
  assign bus.reg_dst     = state_q == WB_R;
  assign bus.mem_to_reg  = state_q == WB_LD;
  assign bus.alu_src_a   = state_q == EXEC_R || state_q == ADDR || state_q == BRANCH;
  assign bus.alu_src_b   = state_q == FETCH ? 2'd1 : state_q == DECODE ? 2'd3 :
                           state_q == ADDR ? 2'd2 : 2'd0;
  assign bus.alu_op      = state_q == EXEC_R ? 2'd2 : state_q == BRANCH ? 2'd1 : 2'd0;
  assign bus.pc_src      = state_q == BRANCH ? 2'd1 : state_q == JUMP ? 2'd2 : 2'd0;
  assign bus.busy        = state_q != IDLE && state_q != FAULT;
  assign bus.fault       = state_q == FAULT;
  assign bus.fault_code  = fc_q;
  assign bus.instr_cnt   = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for mc_ctrl with hand-derived per-state output signatures
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;

  mc_if #(.OPCODE_WIDTH(6), .CNT_WIDTH(32)) bus ();
  mc_ctrl #(.OPCODE_WIDTH(6), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // rd wr iod irw pcw pcc rw rdst m2r asa asb aop psrc busy fault
  localparam logic [17:0] S_IDLE   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] S_FETCHR = 18'b1_0_0_1_1_0_0_0_0_0_01_00_00_1_0;
  localparam logic [17:0] S_FETCHW = 18'b1_0_0_0_0_0_0_0_0_0_01_00_00_1_0;
  localparam logic [17:0] S_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] S_EXR    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_1_0;
  localparam logic [17:0] S_WBR    = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] S_ADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_1_0;
  localparam logic [17:0] S_WBI    = 18'b0_0_0_0_0_0_1_0_0_0_00_00_00_1_0;
  localparam logic [17:0] S_MRD    = 18'b1_0_1_0_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] S_WBLD   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] S_MWR    = 18'b0_1_1_0_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] S_BR     = 18'b0_0_0_0_0_1_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] S_JMP    = 18'b0_0_0_0_1_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] S_FLT    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  function automatic logic [17:0] outs();
    return {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_wrt, bus.pc_wrt, bus.pc_wrt_cond,
            bus.reg_wrt, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.busy, bus.fault};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // inputs are set at posedge+1; outputs checked at posedge+2, then advance one cycle
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1 chk(tag, 64'(outs()), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.opcode = 6'b000000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    do_reset();
    #1 chk("rst_outs", 64'(outs()), 64'(S_IDLE));
    chk("rst_cnt", 64'(bus.instr_cnt), 64'd0);
    chk("rst_fc", 64'(bus.fault_code), 64'd0);
    // R-type
    bus.start = 1'b1;
    cyc("r_idle", S_IDLE);
    bus.start = 1'b0;
    cyc("r_fetch", S_FETCHR);
    cyc("r_dec", S_DEC);
    cyc("r_exec", S_EXR);
    cyc("r_wb", S_WBR);
    chk("r_cnt", 64'(bus.instr_cnt), 64'd1);
    // lw with 3 stalled cycles in MEM_RD
    bus.opcode = 6'b100011;
    cyc("lw_fetch", S_FETCHR);
    cyc("lw_dec", S_DEC);
    cyc("lw_addr", S_ADDR);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw_wait%0d", i), S_MRD);
    bus.mem_ready = 1'b1;
    cyc("lw_mrd", S_MRD);
    cyc("lw_wb", S_WBLD);
    chk("lw_cnt", 64'(bus.instr_cnt), 64'd2);
    // beq taken then not taken
    bus.opcode = 6'b000100;
    bus.zero = 1'b1;
    cyc("beq1_fetch", S_FETCHR);
    cyc("beq1_dec", S_DEC);
    cyc("beq1_br", S_BR);
    bus.zero = 1'b0;
    cyc("beq0_fetch", S_FETCHR);
    cyc("beq0_dec", S_DEC);
    cyc("beq0_br", S_BR);
    chk("beq_cnt", 64'(bus.instr_cnt), 64'd4);
    // addi, sw, j
    bus.opcode = 6'b001000;
    cyc("addi_fetch", S_FETCHR);
    cyc("addi_dec", S_DEC);
    cyc("addi_addr", S_ADDR);
    cyc("addi_wb", S_WBI);
    bus.opcode = 6'b101011;
    cyc("sw_fetch", S_FETCHR);
    cyc("sw_dec", S_DEC);
    cyc("sw_addr", S_ADDR);
    cyc("sw_mwr", S_MWR);
    bus.opcode = 6'b000010;
    cyc("j_fetch", S_FETCHR);
    cyc("j_dec", S_DEC);
    cyc("j_jmp", S_JMP);
    chk("j_cnt", 64'(bus.instr_cnt), 64'd7);
    // ready arrives on the 16th stalled fetch cycle: normal advance
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc($sformatf("tmo_wait%0d", i), S_FETCHW);
    bus.mem_ready = 1'b1;
    cyc("tmo_last_ready", S_FETCHR);
    cyc("tmo_dec", S_DEC);
    cyc("tmo_exec", S_EXR);
    cyc("tmo_wb", S_WBR);
    chk("tmo_cnt", 64'(bus.instr_cnt), 64'd8);
    // 16 stalled fetch cycles: watchdog fault
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc($sformatf("to_wait%0d", i), S_FETCHW);
    bus.mem_ready = 1'b1;
    bus.start = 1'b1;
    cyc("to_fault", S_FLT);
    cyc("to_stuck", S_FLT);
    chk("to_fc", 64'(bus.fault_code), 64'd2);
    chk("to_cnt", 64'(bus.instr_cnt), 64'd8);
    // illegal opcode after one good instruction
    bus.start = 1'b0;
    do_reset();
    #1 chk("rst2_cnt", 64'(bus.instr_cnt), 64'd0);
    chk("rst2_fc", 64'(bus.fault_code), 64'd0);
    bus.start = 1'b1;
    cyc("il_idle", S_IDLE);
    cyc("il_r_fetch", S_FETCHR);
    cyc("il_r_dec", S_DEC);
    cyc("il_r_exec", S_EXR);
    cyc("il_r_wb", S_WBR);
    bus.opcode = 6'b111111;
    cyc("il_fetch", S_FETCHR);
    cyc("il_dec", S_DEC);
    for (int i = 0; i < 3; i++) cyc($sformatf("il_fault%0d", i), S_FLT);
    chk("il_fc", 64'(bus.fault_code), 64'd1);
    chk("il_cnt", 64'(bus.instr_cnt), 64'd1);
    // async reset in the middle of a stalled store
    bus.start = 1'b0;
    do_reset();
    bus.start = 1'b1;
    bus.opcode = 6'b101011;
    cyc("ar_idle", S_IDLE);
    bus.start = 1'b0;
    cyc("ar_fetch", S_FETCHR);
    cyc("ar_dec", S_DEC);
    bus.mem_ready = 1'b0;
    cyc("ar_addr", S_ADDR);
    cyc("ar_mwr", S_MWR);
    #2 rst = 1'b1;
    #1 chk("ar_outs", 64'(outs()), 64'(S_IDLE));
    chk("ar_cnt", 64'(bus.instr_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b000000;
    bus.start = 1'b1;
    cyc("ar2_idle", S_IDLE);
    bus.start = 1'b0;
    cyc("ar2_fetch", S_FETCHR);
    cyc("ar2_dec", S_DEC);
    cyc("ar2_exec", S_EXR);
    cyc("ar2_wb", S_WBR);
    chk("ar2_cnt", 64'(bus.instr_cnt), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
